// File: rtl/damage_accum_if.sv
// Controller-side bundle for the damage accumulator: Start/Ack handshake,
// attack/alive/armour operands and the per-side totals that come back.
interface damage_accum_if #(
    parameter int NUM_SLOTS = 16,
    parameter int ATK_W     = 8,
    parameter int SUM_W     = 12
);
    logic                       start_i;
    logic                       ack_i;
    logic [NUM_SLOTS*ATK_W-1:0] unit_attack_i;
    logic [NUM_SLOTS*ATK_W-1:0] enemy_attack_i;
    logic [NUM_SLOTS-1:0]       unit_alive_i;
    logic [NUM_SLOTS-1:0]       enemy_alive_i;
    logic [ATK_W-1:0]           unit_armor_i;
    logic [ATK_W-1:0]           enemy_armor_i;
    logic [SUM_W-1:0]           total_unit_damage_o;
    logic [SUM_W-1:0]           total_enemy_damage_o;
    logic                       unit_overflow_o;
    logic                       enemy_overflow_o;
    logic                       busy_o;
    logic                       done_o;

    modport master (
        output start_i, ack_i,
        output unit_attack_i, enemy_attack_i,
        output unit_alive_i, enemy_alive_i,
        output unit_armor_i, enemy_armor_i,
        input  total_unit_damage_o, total_enemy_damage_o,
        input  unit_overflow_o, enemy_overflow_o,
        input  busy_o, done_o
    );

    modport slave (
        input  start_i, ack_i,
        input  unit_attack_i, enemy_attack_i,
        input  unit_alive_i, enemy_alive_i,
        input  unit_armor_i, enemy_armor_i,
        output total_unit_damage_o, total_enemy_damage_o,
        output unit_overflow_o, enemy_overflow_o,
        output busy_o, done_o
    );
endinterface

// File: rtl/damage_accum.sv
// Two-side damage accumulator: snapshots all slots on Start, walks one slot
// per clock applying alive mask and armour, reports via Start/Done/Ack.
//
//   state  | meaning
//   IDLE   | waiting for Start; totals/flags hold the last run
//   SUM    | accumulating slot idx_q of the snapshot, both sides in parallel
//   DONE   | results stable; waiting for Ack
module damage_accum #(
    parameter int NUM_SLOTS = 16,
    parameter int ATK_W     = 8,
    parameter int SUM_W     = 12,
    parameter bit SATURATE  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    damage_accum_if.slave bus
);
    localparam int                IDX_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SLOTS - 1);
    localparam logic [SUM_W-1:0]  SUM_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_SUM  = 3'b010,
        S_DONE = 3'b100
    } state_e;

    state_e                              state_q;
    logic [IDX_W-1:0]                    idx_q;
    logic [NUM_SLOTS-1:0][ATK_W-1:0]     unit_atk_q;
    logic [NUM_SLOTS-1:0][ATK_W-1:0]     enemy_atk_q;
    logic [NUM_SLOTS-1:0]                unit_alive_q;
    logic [NUM_SLOTS-1:0]                enemy_alive_q;
    logic [ATK_W-1:0]                    unit_armor_q;
    logic [ATK_W-1:0]                    enemy_armor_q;
    logic [SUM_W-1:0]                    unit_total_q;
    logic [SUM_W-1:0]                    enemy_total_q;
    logic [SUM_W-1:0]                    unit_total_d;
    logic [SUM_W-1:0]                    enemy_total_d;
    logic                                unit_ovf_q;
    logic                                enemy_ovf_q;
    logic                                unit_ovf_d;
    logic                                enemy_ovf_d;
    logic [ATK_W-1:0]                    unit_eff;
    logic [ATK_W-1:0]                    enemy_eff;
    logic [SUM_W:0]                      unit_sum;
    logic [SUM_W:0]                      enemy_sum;

    // Armour at or above the attack yields zero rather than underflowing.
    function automatic logic [ATK_W-1:0] eff_f(
        input logic             alive,
        input logic [ATK_W-1:0] atk,
        input logic [ATK_W-1:0] armor
    );
        eff_f = (alive && (atk > armor)) ? (atk - armor) : '0;
    endfunction

    always_comb begin
        unit_eff  = eff_f(unit_alive_q[idx_q], unit_atk_q[idx_q], unit_armor_q);
        enemy_eff = eff_f(enemy_alive_q[idx_q], enemy_atk_q[idx_q], enemy_armor_q);

        unit_sum  = {1'b0, unit_total_q}  + {{(SUM_W + 1 - ATK_W){1'b0}}, unit_eff};
        enemy_sum = {1'b0, enemy_total_q} + {{(SUM_W + 1 - ATK_W){1'b0}}, enemy_eff};

        unit_ovf_d  = unit_ovf_q  | unit_sum[SUM_W];
        enemy_ovf_d = enemy_ovf_q | enemy_sum[SUM_W];

        unit_total_d  = unit_sum[SUM_W-1:0];
        enemy_total_d = enemy_sum[SUM_W-1:0];
        if (SATURATE && unit_sum[SUM_W]) begin
            unit_total_d = SUM_MAX;
        end
        if (SATURATE && enemy_sum[SUM_W]) begin
            enemy_total_d = SUM_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            unit_atk_q    <= '0;
            enemy_atk_q   <= '0;
            unit_alive_q  <= '0;
            enemy_alive_q <= '0;
            unit_armor_q  <= '0;
            enemy_armor_q <= '0;
            unit_total_q  <= '0;
            enemy_total_q <= '0;
            unit_ovf_q    <= 1'b0;
            enemy_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        unit_atk_q    <= bus.unit_attack_i;
                        enemy_atk_q   <= bus.enemy_attack_i;
                        unit_alive_q  <= bus.unit_alive_i;
                        enemy_alive_q <= bus.enemy_alive_i;
                        unit_armor_q  <= bus.unit_armor_i;
                        enemy_armor_q <= bus.enemy_armor_i;
                        unit_total_q  <= '0;
                        enemy_total_q <= '0;
                        unit_ovf_q    <= 1'b0;
                        enemy_ovf_q   <= 1'b0;
                        idx_q         <= '0;
                        state_q       <= S_SUM;
                    end
                end
                S_SUM: begin
                    unit_total_q  <= unit_total_d;
                    enemy_total_q <= enemy_total_d;
                    unit_ovf_q    <= unit_ovf_d;
                    enemy_ovf_q   <= enemy_ovf_d;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    // Start arriving with Ack is dropped; it must be re-raised in IDLE.
                    if (bus.ack_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o               = state_q[1];
    assign bus.done_o               = state_q[2];
    assign bus.total_unit_damage_o  = unit_total_q;
    assign bus.total_enemy_damage_o = enemy_total_q;
    assign bus.unit_overflow_o      = unit_ovf_q;
    assign bus.enemy_overflow_o     = enemy_ovf_q;
endmodule

// File: tb/tb_damage_accum.sv
// Bench for damage_accum: four instances (default, SUM_W=10 saturating,
// SUM_W=10 wrapping, 2 slots) share one stimulus stream and one reference model.
module tb_damage_accum;
    localparam int N  = 16;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              start, ack;
    logic [N*AW-1:0]   ua, ea;
    logic [N-1:0]      ual, eal;
    logic [AW-1:0]     uar, ear;

    logic [N*AW-1:0]   sua, sea;
    logic [N-1:0]      sual, seal;
    logic [AW-1:0]     suar, sear;

    int checks = 0;
    int errors = 0;

    damage_accum_if #(.NUM_SLOTS(16), .ATK_W(8), .SUM_W(12)) if_a ();
    damage_accum_if #(.NUM_SLOTS(16), .ATK_W(8), .SUM_W(10)) if_b ();
    damage_accum_if #(.NUM_SLOTS(16), .ATK_W(8), .SUM_W(10)) if_c ();
    damage_accum_if #(.NUM_SLOTS(2),  .ATK_W(8), .SUM_W(12)) if_d ();

    assign if_a.start_i = start;  assign if_a.ack_i = ack;
    assign if_a.unit_attack_i = ua;  assign if_a.enemy_attack_i = ea;
    assign if_a.unit_alive_i = ual;  assign if_a.enemy_alive_i = eal;
    assign if_a.unit_armor_i = uar;  assign if_a.enemy_armor_i = ear;
    assign if_b.start_i = start;  assign if_b.ack_i = ack;
    assign if_b.unit_attack_i = ua;  assign if_b.enemy_attack_i = ea;
    assign if_b.unit_alive_i = ual;  assign if_b.enemy_alive_i = eal;
    assign if_b.unit_armor_i = uar;  assign if_b.enemy_armor_i = ear;
    assign if_c.start_i = start;  assign if_c.ack_i = ack;
    assign if_c.unit_attack_i = ua;  assign if_c.enemy_attack_i = ea;
    assign if_c.unit_alive_i = ual;  assign if_c.enemy_alive_i = eal;
    assign if_c.unit_armor_i = uar;  assign if_c.enemy_armor_i = ear;
    assign if_d.start_i = start;  assign if_d.ack_i = ack;
    assign if_d.unit_attack_i = ua[2*AW-1:0];  assign if_d.enemy_attack_i = ea[2*AW-1:0];
    assign if_d.unit_alive_i = ual[1:0];  assign if_d.enemy_alive_i = eal[1:0];
    assign if_d.unit_armor_i = uar;  assign if_d.enemy_armor_i = ear;

    damage_accum #(.NUM_SLOTS(16), .ATK_W(8), .SUM_W(12), .SATURATE(1'b1))
        u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    damage_accum #(.NUM_SLOTS(16), .ATK_W(8), .SUM_W(10), .SATURATE(1'b1))
        u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    damage_accum #(.NUM_SLOTS(16), .ATK_W(8), .SUM_W(10), .SATURATE(1'b0))
        u_c (.clk(clk), .rst(rst), .bus(if_c.slave));
    damage_accum #(.NUM_SLOTS(2), .ATK_W(8), .SUM_W(12), .SATURATE(1'b1))
        u_d (.clk(clk), .rst(rst), .bus(if_d.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Whole-run arithmetic: sum the effective damages, then apply clamp or wrap.
    function automatic void model(input logic [N*AW-1:0] atk, input logic [N-1:0] alive,
                                  input logic [AW-1:0] armor, input int n, input int sw,
                                  input bit sat, output int total, output bit ovf);
        int raw = 0;
        int maxv = (1 << sw) - 1;
        for (int k = 0; k < n; k++) begin
            int a = int'(atk[k*AW +: AW]);
            if (alive[k] && a > int'(armor)) raw += a - int'(armor);
        end
        ovf   = raw > maxv;
        total = !ovf ? raw : (sat ? maxv : raw % (maxv + 1));
    endfunction

    task automatic check_results(input string tag);
        int t;
        bit o;
        model(sua, sual, suar, 16, 12, 1'b1, t, o);
        chk({tag, ".a_unit_total"}, 32'(if_a.total_unit_damage_o), t);
        chk({tag, ".a_unit_ovf"}, 32'(if_a.unit_overflow_o), 32'(o));
        model(sea, seal, sear, 16, 12, 1'b1, t, o);
        chk({tag, ".a_enemy_total"}, 32'(if_a.total_enemy_damage_o), t);
        chk({tag, ".a_enemy_ovf"}, 32'(if_a.enemy_overflow_o), 32'(o));
        model(sua, sual, suar, 16, 10, 1'b1, t, o);
        chk({tag, ".b_unit_total"}, 32'(if_b.total_unit_damage_o), t);
        chk({tag, ".b_unit_ovf"}, 32'(if_b.unit_overflow_o), 32'(o));
        model(sea, seal, sear, 16, 10, 1'b1, t, o);
        chk({tag, ".b_enemy_total"}, 32'(if_b.total_enemy_damage_o), t);
        chk({tag, ".b_enemy_ovf"}, 32'(if_b.enemy_overflow_o), 32'(o));
        model(sua, sual, suar, 16, 10, 1'b0, t, o);
        chk({tag, ".c_unit_total"}, 32'(if_c.total_unit_damage_o), t);
        chk({tag, ".c_unit_ovf"}, 32'(if_c.unit_overflow_o), 32'(o));
        model(sea, seal, sear, 16, 10, 1'b0, t, o);
        chk({tag, ".c_enemy_total"}, 32'(if_c.total_enemy_damage_o), t);
        chk({tag, ".c_enemy_ovf"}, 32'(if_c.enemy_overflow_o), 32'(o));
        model(sua, sual, suar, 2, 12, 1'b1, t, o);
        chk({tag, ".d_unit_total"}, 32'(if_d.total_unit_damage_o), t);
        chk({tag, ".d_unit_ovf"}, 32'(if_d.unit_overflow_o), 32'(o));
        model(sea, seal, sear, 2, 12, 1'b1, t, o);
        chk({tag, ".d_enemy_total"}, 32'(if_d.total_enemy_damage_o), t);
        chk({tag, ".d_enemy_ovf"}, 32'(if_d.enemy_overflow_o), 32'(o));
    endtask

    // Caller sets the inputs; all DUTs must be in IDLE. The run is always acked.
    task automatic do_run(input string tag, input bit mutate, input bit ack_with_start);
        sua = ua; sea = ea; sual = ual; seal = eal; suar = uar; sear = ear;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, ".busy_after_accept"}, 32'(if_a.busy_o), 1);
        chk({tag, ".done_after_accept"}, 32'(if_a.done_o), 0);
        chk({tag, ".d_busy_after_accept"}, 32'(if_d.busy_o), 1);
        for (int k = 1; k < N; k++) begin
            step();
            if (k == 1) chk({tag, ".d_done_early"}, 32'(if_d.done_o), 0);
            if (k == 2) chk({tag, ".d_done_latency"}, 32'(if_d.done_o), 1);
            if (mutate && k == 3) begin
                ua = '0; ea = '0; ual = '1; eal = '1; uar = '0; ear = '0;
            end
            if (mutate && k == 5) start = 1'b1;
            if (mutate && k == 6) begin
                start = 1'b0;
                chk({tag, ".busy_start_in_sum"}, 32'(if_a.busy_o), 1);
            end
        end
        chk({tag, ".done_before_last"}, 32'(if_a.done_o), 0);
        step();
        chk({tag, ".done_latency"}, 32'(if_a.done_o), 1);
        chk({tag, ".busy_in_done"}, 32'(if_a.busy_o), 0);
        chk({tag, ".c_done_latency"}, 32'(if_c.done_o), 1);
        check_results(tag);
        step();
        step();
        chk({tag, ".done_holds"}, 32'(if_a.done_o), 1);
        ack   = 1'b1;
        start = ack_with_start;
        step();
        ack = 1'b0;
        chk({tag, ".done_after_ack"}, 32'(if_a.done_o), 0);
        chk({tag, ".busy_after_ack"}, 32'(if_a.busy_o), 0);
        chk({tag, ".d_done_after_ack"}, 32'(if_d.done_o), 0);
        check_results({tag, ".hold"});
    endtask

    task automatic fill_all(input logic [AW-1:0] u, input logic [AW-1:0] e);
        for (int k = 0; k < N; k++) begin
            ua[k*AW +: AW] = u;
            ea[k*AW +: AW] = e;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ack = 1'b0;
        ua = '0; ea = '0; ual = '0; eal = '0; uar = '0; ear = '0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset.busy", 32'(if_a.busy_o), 0);
        chk("reset.done", 32'(if_a.done_o), 0);
        chk("reset.unit_total", 32'(if_a.total_unit_damage_o), 0);
        chk("reset.enemy_ovf", 32'(if_a.enemy_overflow_o), 0);

        fill_all(8'd10, 8'd10); ual = '1; eal = '1;
        do_run("base", 1'b0, 1'b0);
        chk("base.a_unit_160", 32'(if_a.total_unit_damage_o), 160);

        for (int k = 0; k < N; k++) ua[k*AW +: AW] = (k % 2 == 0) ? 8'd2 : 8'd5;
        uar = 8'd3; ear = 8'd255;
        do_run("armor", 1'b0, 1'b0);
        chk("armor.a_unit_16", 32'(if_a.total_unit_damage_o), 16);

        fill_all(8'd20, 8'd20); uar = '0; ear = '0; ual = '0; eal = 16'h00FF;
        do_run("alive", 1'b0, 1'b0);
        chk("alive.a_enemy_160", 32'(if_a.total_enemy_damage_o), 160);

        fill_all(8'd255, 8'd255); ual = '1; eal = '1;
        do_run("sat", 1'b0, 1'b0);
        chk("sat.b_unit_1023", 32'(if_b.total_unit_damage_o), 1023);
        chk("sat.c_unit_1008", 32'(if_c.total_unit_damage_o), 1008);
        chk("sat.a_unit_4080", 32'(if_a.total_unit_damage_o), 4080);

        // Snapshot isolation, Start during SUM, then Start held with Ack.
        fill_all(8'd30, 8'd7); ual = 16'hF0F0; eal = 16'h1234; uar = 8'd4; ear = 8'd1;
        do_run("mutate", 1'b1, 1'b1);
        fill_all(8'd12, 8'd9); ual = '1; eal = 16'h5555; uar = 8'd2; ear = 8'd0;
        do_run("backtoback", 1'b0, 1'b0);

        fill_all(8'd50, 8'd60); ual = '1; eal = '1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midreset.busy", 32'(if_a.busy_o), 0);
        chk("midreset.done", 32'(if_a.done_o), 0);
        chk("midreset.unit_total", 32'(if_a.total_unit_damage_o), 0);
        chk("midreset.enemy_total", 32'(if_a.total_enemy_damage_o), 0);
        chk("midreset.d_done", 32'(if_d.done_o), 0);
        repeat (20) step();
        chk("midreset.no_result", 32'(if_a.done_o), 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("idle_ack.busy", 32'(if_a.busy_o), 0);
        chk("idle_ack.done", 32'(if_a.done_o), 0);
        chk("idle_ack.total", 32'(if_a.total_unit_damage_o), 0);

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < N; k++) begin
                ua[k*AW +: AW] = AW'((r < 4) ? $urandom_range(0, 255) : $urandom_range(180, 255));
                ea[k*AW +: AW] = AW'((r < 4) ? $urandom_range(0, 255) : $urandom_range(180, 255));
            end
            ual = N'($urandom);
            eal = (r >= 4) ? '1 : N'($urandom);
            uar = AW'($urandom_range(0, (r < 4) ? 120 : 10));
            ear = AW'($urandom_range(0, (r < 4) ? 255 : 10));
            do_run($sformatf("rand%0d", r), 1'b0, r[0]);
        end
        start = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/damage_accum.md
Name: damage_accum

Overview:
- Parametrised multi-slot damage accumulator for the combat-resolution path; next generation of the fixed 16-slot, two-side damage summer.
- On Start it snapshots every unit-side and enemy-side attack value. It then walks the slots one per clock.
- Per slot it applies the alive mask and the side's armour, and accumulates per-side totals with optional saturation. It reports results through a Start/Done/Ack handshake to the game controller.

Parameters:
- NUM_SLOTS, 16: slots per side; legal range 2..64.
- ATK_W, 8: width of each attack value and of each armour input.
- SUM_W, 12: width of each total; must be ≥ ATK_W.
- SATURATE, 1: 1 = totals clamp at 2^SUM_W-1; 0 = totals wrap modulo 2^SUM_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- Start  in  1  request a calculation; accepted only in IDLE.
- Ack  in  1  result consumed; honoured only in DONE.
- unitAttack  in  NUM_SLOTS*ATK_W  packed attack values; slot k occupies bits [k*ATK_W +: ATK_W].
- enemyAttack  in  NUM_SLOTS*ATK_W  same packing as unitAttack.
- unitAlive  in  NUM_SLOTS  bit k=1 means unit slot k contributes.
- enemyAlive  in  NUM_SLOTS  same meaning for enemy slots.
- unitArmor  in  ATK_W  armour subtracted from every unit-side slot.
- enemyArmor  in  ATK_W  armour subtracted from every enemy-side slot.
- totalUnitDamage  out  SUM_W  unit-side total.
- totalEnemyDamage  out  SUM_W  enemy-side total.
- unitOverflow  out  1  sticky; set when the unit total exceeded 2^SUM_W-1 this run.
- enemyOverflow  out  1  sticky; same for the enemy total.
- Busy  out  1  high in SUM.
- Done  out  1  high in DONE.

Behaviour:
- States: IDLE, SUM, DONE. Encoding is one-hot. Done and Busy are decoded directly from state bits.
- Slot index I is a counter of width max(1, clog2(NUM_SLOTS)).
- Reset: state=IDLE, I=0, totals=0, both overflow flags=0, Done=0, Busy=0.
  - Reset in any state, including mid-SUM, aborts the run immediately; no partial result is presented.
- IDLE:
  - Start=1 accepts; state goes to SUM next cycle.
  - On acceptance, in the same edge: snapshot unitAttack, enemyAttack, both Alive masks and both armours into internal registers; clear totals and overflow flags; set I=0.
  - Start=0: stay in IDLE; totals and flags hold the previous run's values.
- SUM: one slot per clock, slot I from the snapshot.
  - Effective damage eff = alive[I] ? (atk[I] > armor ? atk[I]-armor : 0) : 0.
  - Addition is done at SUM_W+1 bits.
  - If the carry is set: the overflow flag sets (sticky). The total becomes 2^SUM_W-1 when SATURATE=1, or the low SUM_W bits when SATURATE=0.
  - Once saturated, the total stays at 2^SUM_W-1.
  - When I=NUM_SLOTS-1, go to DONE; otherwise I increments.
- Latency: Start accepted at edge T → SUM occupies edges T+1..T+NUM_SLOTS → Done=1 from edge T+NUM_SLOTS on (visible in cycle T+NUM_SLOTS+1).
  - For 16 slots, Done rises 17 cycles after the accepting edge.
- DONE:
  - Totals and flags are stable; Done stays high until Ack=1.
  - Ack=1 → IDLE next cycle. Done falls; totals and flags still hold.
- Input handling:
  - Start outside IDLE is ignored and not queued.
  - Ack outside DONE is ignored.
  - Start and Ack both high in DONE → go to IDLE only; Start must be reasserted in IDLE.
  - Live input changes after acceptance have no effect on the current run (snapshot).
- Armour ≥ attack gives eff=0; subtraction never underflows.
- Both sides are computed in parallel in the same cycle and have identical timing.

Test Plan:
- Default params, all attacks 10, all alive, armour 0, Start pulse → Done exactly 17 cycles after the accepting edge; totals 160/160; flags 0.
- unitArmor=3; unit slots alternate 2 and 5 → unit total 16; enemyArmor=255 → enemy total 0.
- enemyAlive=16'h00FF, enemy attacks all 20 → enemy total 160; unitAlive=0 → unit total 0.
- Bench SUM_W=10, all attacks 255:
  - SATURATE=1 → totals 1023, both flags 1.
  - SATURATE=0 → totals 1008, both flags 1.
  - SUM_W=12 → totals 4080, flags 0.
- Start at edge T, then change every attack to 0 at T+3 → totals still those of the snapshot. A Start pulse during SUM is ignored. Holding Start and Ack high together in DONE → exactly one IDLE cycle before the next run.
- Assert rst at the 5th SUM cycle → next cycle IDLE, totals 0, Done 0. Ack pulse in IDLE → no state change. NUM_SLOTS=2 run → Done 3 cycles after accept.
